// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite pixel memory and its byte-stream loader.
package sprite_pkg;
  localparam int SPRITE_W = 64;
  localparam int SPRITE_H = 64;
  localparam int ADDR_W = 12;
  localparam int PIX_W = 12;
  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_HI  = 2'd1,
    S_LO  = 2'd2
  } loader_state_t;

  typedef logic [PIX_W-1:0] pixel_t;
endpackage

// File: rtl/sprite_dpram.sv
// 4096 x 12 simple dual-port sprite RAM, registered read-first read port.
module sprite_dpram
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  pixel_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output pixel_t            rdata
);

  pixel_t mem [SPRITE_W*SPRITE_H];

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port samples the pre-write contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sprite_ram_loader.sv
// Fills the sprite RAM from a header-framed byte stream and serves draw-stage reads.
module sprite_ram_loader
  import sprite_pkg::*;
#(
  parameter int TIMEOUT = 100_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic              frame_valid,
  output logic              error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] EXPIRE = CNT_W'(TIMEOUT - 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SPRITE_W * SPRITE_H - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]        hi_q, hi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q;
  logic              done_q, done_d;
  logic              fv_q, fv_d;
  logic              err_q, err_d;
  logic              we_s;
  pixel_t            wdata_s;
  logic              expire_s;

  // Expiry fires on the idle cycle whose increment would reach TIMEOUT-1.
  assign expire_s = (state_q != S_HDR) && !rx_valid && (cnt_q == EXPIRE);

  // Next-state, write strobe and pulse generation.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    hi_d      = hi_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    fv_d      = fv_q;
    err_d     = 1'b0;
    we_s      = 1'b0;
    wdata_s   = {hi_q, rx_data};
    case (state_q)
      S_HDR: begin
        cnt_d = '0;
        if (rx_valid && (rx_data == HEADER)) begin
          state_d   = S_HI;
          wr_addr_d = '0;
          fv_d      = 1'b0;
        end else begin
          state_d = S_HDR;
        end
      end
      S_HI, S_LO: begin
        if (rx_valid) begin
          cnt_d = '0;
          if (state_q == S_HI) begin
            hi_d    = rx_data[3:0];
            state_d = S_LO;
          end else begin
            we_s = 1'b1;
            if (wr_addr_q == LAST_ADDR) begin
              wr_addr_d = '0;
              done_d    = 1'b1;
              fv_d      = 1'b1;
              state_d   = S_HDR;
            end else begin
              wr_addr_d = wr_addr_q + ADDR_W'(1);
              state_d   = S_HI;
            end
          end
        end else if (expire_s) begin
          cnt_d     = '0;
          wr_addr_d = '0;
          err_d     = 1'b1;
          state_d   = S_HDR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = S_HDR;
        wr_addr_d = '0;
        cnt_d     = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HDR;
      wr_addr_q <= '0;
      hi_q      <= 4'h0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      hi_q      <= hi_d;
      cnt_q     <= cnt_d;
      busy_q    <= (state_d != S_HDR);
      done_q    <= done_d;
      fv_q      <= fv_d;
      err_q     <= err_d;
    end
  end

  sprite_dpram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we_s),
    .waddr (wr_addr_q),
    .wdata (wdata_s),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_valid = fv_q;
  assign error       = err_q;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Directed self-checking bench for sprite_ram_loader (short timeout for fast runs).
module tb_sprite_ram_loader;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [11:0] rd_addr = 12'h000;
  logic [11:0] rd_data;
  logic        busy, done, frame_valid, error;

  int checks = 0;
  int errors = 0;

  sprite_ram_loader #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .frame_valid (frame_valid),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_pixel(input logic [11:0] p);
    send_byte({4'h0, p[11:8]});
    send_byte(p[7:0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic read_check(input logic [11:0] a, input logic [11:0] exp, input string name);
    rd_addr = a;
    @(posedge clk); #1;
    checks++;
    if (rd_data !== exp) begin
      errors++;
      $display("FAIL %s: rd_data=%h expected %h", name, rd_data, exp);
    end
  endtask

  // Full frame with pixel n = n ^ key, checking done and frame_valid.
  task automatic send_frame(input logic [11:0] key, input string name);
    int dcnt = 0;
    send_byte(8'hA5);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_fv_drop: frame_valid=%b expected 0", name, frame_valid);
    end
    for (int n = 0; n < 4096; n++) begin
      send_pixel(12'(n) ^ key);
      if (done) dcnt++;
    end
    checks++;
    if (done !== 1'b1 || dcnt != 1) begin
      errors++;
      $display("FAIL %s_done: done=%b pulses=%0d expected 1/1", name, done, dcnt);
    end
    checks++;
    if (frame_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_fv: frame_valid=%b busy=%b expected 1/0", name, frame_valid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_len: done=%b expected 0", name, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rd_data, busy, done, frame_valid, error} !== 16'h0000) begin
      errors++;
      $display("FAIL reset: rd_data=%h busy=%b done=%b fv=%b err=%b expected all 0",
               rd_data, busy, done, frame_valid, error);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    send_frame(12'h000, "frame1");
    read_check(12'h041, 12'h041, "frame1_rd041");
    read_check(12'hFFF, 12'hFFF, "frame1_rdFFF");
  endtask

  task automatic test_header_sync();
    send_byte(8'h00);
    send_byte(8'h3C);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hdr_drop: busy=%b expected 0", busy);
    end
    send_byte(8'hA5);
    checks++;
    if (busy !== 1'b1 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL hdr_accept: busy=%b fv=%b expected 1/0", busy, frame_valid);
    end
    send_byte(8'h0F);
    send_byte(8'hF0);
    read_check(12'h000, 12'hFF0, "hdr_ram0");
    do_reset();
  endtask

  task automatic test_timeout();
    int ecnt = 0;
    int ek = -1;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h23);
    for (int k = 1; k <= TO + 5; k++) begin
      @(posedge clk); #1;
      if (error) begin
        ecnt++;
        ek = k;
      end
    end
    checks++;
    if (ecnt != 1 || ek != TO - 1) begin
      errors++;
      $display("FAIL timeout_err: pulses=%0d at=%0d expected 1 at %0d", ecnt, ek, TO - 1);
    end
    checks++;
    if (busy !== 1'b0 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: busy=%b fv=%b expected 0/0", busy, frame_valid);
    end
    read_check(12'h000, 12'h123, "timeout_ram0");
    send_frame(12'h3C3, "frame_after_to");
    read_check(12'h000, 12'h3C3, "after_to_ram0");
    read_check(12'hFFF, 12'hC3C, "after_to_ramFFF");
  endtask

  task automatic test_reload();
    send_byte(8'hA5);
    checks++;
    if (frame_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reload_fv: fv=%b busy=%b expected 0/1", frame_valid, busy);
    end
    send_byte(8'h0A);
    send_byte(8'hBC);
    read_check(12'h000, 12'hABC, "reload_ram0");
    read_check(12'h001, 12'h3C2, "reload_ram1");
    do_reset();
  endtask

  task automatic test_reset_midframe();
    send_byte(8'hA5);
    for (int n = 0; n < 100; n++) send_pixel(12'(n) ^ 12'h5A5);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rd_data, busy, done, frame_valid, error} !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_out: rd_data=%h busy=%b done=%b fv=%b err=%b expected all 0",
               rd_data, busy, done, frame_valid, error);
    end
    rst = 1'b0;
    read_check(12'd0,   12'h5A5,            "midrst_ram0");
    read_check(12'd50,  12'd50 ^ 12'h5A5,   "midrst_ram50");
    read_check(12'd99,  12'd99 ^ 12'h5A5,   "midrst_ram99");
    read_check(12'd100, 12'd100 ^ 12'h3C3,  "midrst_ram100");
    send_frame(12'h000, "frame_after_rst");
    read_check(12'd99, 12'd99, "after_rst_ram99");
  endtask

  task automatic test_rw_collision();
    send_byte(8'hA5);
    for (int n = 0; n < 5; n++) send_pixel(12'(n) ^ 12'h0F0);
    rd_addr = 12'd5;
    send_byte(8'h0A);
    send_byte(8'hA5);
    checks++;
    if (rd_data !== 12'h005) begin
      errors++;
      $display("FAIL rw_old: rd_data=%h expected 005", rd_data);
    end
    @(posedge clk); #1;
    checks++;
    if (rd_data !== 12'hAA5) begin
      errors++;
      $display("FAIL rw_new: rd_data=%h expected aa5", rd_data);
    end
    send_byte(8'hA5);
    send_byte(8'h00);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL hdr_as_data: busy=%b expected 1", busy);
    end
    read_check(12'd6, 12'h500, "hdr_as_data_ram6");
    read_check(12'd4, 12'h0F4, "rw_ram4");
    do_reset();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_header_sync();
    test_timeout();
    test_reload();
    test_reset_midframe();
    test_rw_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_ram_loader.md
Name: sprite_ram_loader

Overview:
Loads a 64x64, 12-bit RGB sprite from a byte stream (UART receiver output) into an internal dual-port RAM. It serves the pixel_addr -> rgb_pixel read side consumed by the sprite/rectangle drawing stage in the VGA pipeline.
It is the writer/responder end of the sprite pixel memory. The draw stage only reads; this block fills the memory and answers the reads.
Pixel address format is {row[5:0], col[5:0]}.

Parameters:
ADDR_W, 12, sprite RAM address width (64*64 = 4096 words)
PIX_W, 12, pixel width, {R[3:0], G[3:0], B[3:0]}
HEADER, 8'hA5, frame-start byte
TIMEOUT, 100_000, max clk cycles allowed between bytes inside a frame

Ports:
clk  in  1  system clock (VGA pixel clock domain)
rst  in  1  synchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
rd_addr  in  ADDR_W  read address from draw stage
rd_data  out  PIX_W  pixel at rd_addr, 1-cycle latency
busy  out  1  frame load in progress
done  out  1  one-cycle pulse, last pixel written
frame_valid  out  1  complete sprite present in RAM
error  out  1  one-cycle pulse, inter-byte timeout aborted a frame

Behaviour:
- Reset (clk, rst synchronous active-high):
  - Outputs: rd_data=0, busy=0, done=0, frame_valid=0, error=0.
  - Internal: state=S_HDR, wr_addr=0, hi_reg=0, timeout counter=0.
  - RAM contents are not cleared.
- FSM states:
  - S_HDR:
    - rx_valid with rx_data==HEADER -> S_HI, wr_addr=0, frame_valid=0.
    - Any other byte is dropped; state unchanged.
  - S_HI:
    - rx_valid -> hi_reg <= rx_data[3:0], go to S_LO.
    - rx_data[7:4] is ignored.
  - S_LO:
    - rx_valid -> RAM write at that clock edge: addr=wr_addr, data={hi_reg, rx_data}.
    - If wr_addr==4095: wr_addr wraps to 0, done=1 for the next cycle, frame_valid=1, go to S_HDR.
    - Otherwise: wr_addr++, go to S_HI.
- busy = (state != S_HDR), registered with the state.
- A HEADER byte seen in S_HI or S_LO is treated as pixel data, not as a resync.
- Timeout:
  - Counter clears on every rx_valid and while in S_HDR.
  - In S_HI/S_LO it increments each cycle without rx_valid.
  - When it reaches TIMEOUT-1: go to S_HDR, wr_addr=0, error=1 for one cycle, frame_valid stays 0.
  - rx_valid in the same cycle as the expiry wins: the byte is accepted and the counter clears.
- Read port:
  - rd_data <= ram[rd_addr] every cycle, regardless of state.
  - Read and write to the same address in one cycle returns the old data (read-first).
- frame_valid drops on header acceptance, so the draw stage can blank the sprite during a reload.
- Reset mid-frame: FSM returns to S_HDR. Partial data stays in RAM; frame_valid=0 until a full frame loads.
- A frame is exactly 1 header + 8192 bytes. Bytes after done and before the next header are ignored.

Decomposition:
- Package sprite_pkg:
  - SPRITE_W=64, SPRITE_H=64, ADDR_W, PIX_W, HEADER.
  - Typedef loader_state_t enum {S_HDR, S_HI, S_LO}.
  - Typedef pixel_t logic [PIX_W-1:0].
- Sub-module sprite_dpram:
  - Simple dual-port RAM, 4096 x 12.
  - Write port: we, waddr, wdata. Registered read port: raddr, rdata. Read-first.
  - Inferable as BRAM.
- The FSM, address counter and timeout counter live in sprite_ram_loader.

Test Plan:
1. Reset, then A5 followed by 8192 bytes (hi=n[11:8], lo=n[7:0], n = address) -> done pulses once after the last byte; frame_valid=1; rd_addr=12'h041 gives rd_data=12'h041 one cycle later; rd_addr=12'hFFF gives 12'hFFF.
2. Bytes 00,3C,A5,0F,F0 -> first two dropped; busy=1 after A5; ram[0]=12'hFF0; frame_valid=0.
3. A5,01,23 then idle TIMEOUT cycles -> error pulses exactly once at cycle TIMEOUT-1; busy=0. Then a full valid frame loads normally from address 0.
4. After a good frame, send A5,0A,BC -> frame_valid falls on A5 acceptance; ram[0]=12'hABC; ram[1] keeps its old value.
5. rst asserted after 100 pixels -> all outputs 0 the next cycle; ram[0..99] retain written values; a subsequent frame completes correctly.
6. Write pixel 5 while rd_addr=5 in the same cycle -> rd_data shows the old value, then the new value one cycle later. A HEADER value sent as a data byte is stored as pixel data.
